key_debounce_sampler: RTL

- Per-finger button conditioner that sits directly upstream of the clocked D latch stage.
- Synchronises raw pad inputs, rejects contact bounce, and produces a clean level plus a one-cycle enable for each key.
- The level drives the latch data input (D) and the strobe drives its enable (C), so the latch only opens on a validated edge.
- Also emits press/release pulses for the game scoring logic.

---
 rtl/key_debounce_sampler_pkg.sv | 13 +
 rtl/key_debounce_channel.sv | 78 +++++++
 rtl/key_debounce_sampler.sv | 36 +++
 3 files changed

// File: rtl/key_debounce_sampler_pkg.sv
// Shared debounce defaults, so game timing and the key conditioner agree on clock rate.
package key_debounce_sampler_pkg;

  localparam int unsigned DEF_STABLE_CYCLES  = 50000;  // 1 ms at 50 MHz
  localparam int unsigned DEF_CNT_WIDTH      = 16;
  localparam int unsigned DEF_KEY_ACTIVE_LOW = 1;

  // Maps a raw pad bit onto the active-high "pressed" sense.
  function automatic logic key_pressed(input logic raw, input logic active_low);
    return active_low ? ~raw : raw;
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One key: two-flop synchroniser, stability counter, debounced level and
// registered strobe / press / release pulses that update on the same edge.
module key_debounce_channel
  import key_debounce_sampler_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int unsigned CNT_WIDTH      = DEF_CNT_WIDTH,
  parameter int unsigned KEY_ACTIVE_LOW = DEF_KEY_ACTIVE_LOW
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_level,
  output logic latch_en,
  output logic key_press,
  output logic key_release
);

  localparam logic [CNT_WIDTH-1:0] TERM_CNT = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 level_q, level_d;
  logic                 latch_en_q, latch_en_d;
  logic                 press_q, press_d;
  logic                 release_q, release_d;
  logic                 s;

  // Polarity is folded in front of the first flop (a plain inverter), so the
  // synchroniser holds pressed-sense bits and its reset value of 0 means "not pressed".
  assign sync1_d = key_pressed(key_raw, KEY_ACTIVE_LOW != 0);
  assign sync2_d = sync1_q;
  assign s       = sync2_q;

  always_comb begin
    cnt_d      = cnt_q;
    level_d    = level_q;
    latch_en_d = 1'b0;
    if (s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == TERM_CNT) begin
      cnt_d      = '0;
      level_d    = s;
      latch_en_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
    press_d   = latch_en_d & s;
    release_d = latch_en_d & ~s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      cnt_q      <= '0;
      level_q    <= 1'b0;
      latch_en_q <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      latch_en_q <= latch_en_d;
      press_q    <= press_d;
      release_q  <= release_d;
    end
  end

  assign key_level   = level_q;
  assign latch_en    = latch_en_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: rtl/key_debounce_sampler.sv
// Per-finger button conditioner feeding the clocked D latch stage:
// key_level drives latch D, latch_en drives latch C.
module key_debounce_sampler
  import key_debounce_sampler_pkg::*;
#(
  parameter int unsigned NUM_KEYS       = 4,
  parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int unsigned CNT_WIDTH      = DEF_CNT_WIDTH,
  parameter int unsigned KEY_ACTIVE_LOW = DEF_KEY_ACTIVE_LOW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] latch_en,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_WIDTH     (CNT_WIDTH),
      .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_raw    (key_raw[i]),
      .key_level  (key_level[i]),
      .latch_en   (latch_en[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i])
    );
  end

endmodule
